// File: rtl/evt_code_serializer_pkg.sv
// Shared types and constants for the event-code serializer.
// Event vectors are one-hot/multi-hot per line; codes are binary line indices.
package evt_code_pkg;

  localparam int N_EVT  = 8;
  localparam int CODE_W = $clog2(N_EVT);

  typedef logic [N_EVT-1:0]  evt_vec_t;
  typedef logic [CODE_W-1:0] evt_code_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/evt_code_serializer_if.sv
// Code stream between the serializer (master) and the code consumer (slave).
// Handshake: a transfer happens on every rising edge where code_valid && code_ready;
// while code_valid is high and code_ready is low, code_out and code_valid hold steady.
interface evt_code_serializer_if;
  import evt_code_pkg::*;

  evt_code_t code_out;
  logic      code_valid;
  logic      code_ready;

  modport master (
    output code_out,
    output code_valid,
    input  code_ready
  );

  modport slave (
    input  code_out,
    input  code_valid,
    output code_ready
  );

endinterface

// File: rtl/evt_code_serializer_rr_pick.sv
// Round-robin finder: first set bit of pending at or above ptr, wrapping 7 -> 0.
module evt_rr_pick
  import evt_code_pkg::*;
(
  input  evt_vec_t  pending,
  input  evt_code_t ptr,
  output logic      found,
  output evt_code_t idx
);

  evt_vec_t  rot;
  evt_code_t off;

  // Rotating a doubled copy puts bit ptr at position 0, so a plain
  // lowest-bit priority scan gives the distance from ptr.
  always_comb begin
    rot   = evt_vec_t'({pending, pending} >> ptr);
    found = |rot;
    off   = '0;
    for (int j = N_EVT - 1; j >= 0; j--) begin
      if (rot[j]) off = evt_code_t'(j);
    end
    idx = ptr + off;
  end

endmodule

// File: rtl/evt_code_serializer.sv
// Captures event strobes as pending bits and emits them one at a time as
// binary codes on a valid/ready stream, with round-robin arbitration.
module evt_code_serializer
  import evt_code_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  evt_vec_t                     evt_in,
  evt_code_serializer_if.master        stream,
  output evt_vec_t                     pending,
  output logic                         overflow,
  output slot_state_t                  slot_state
);

  evt_code_t ptr;
  logic      pick_found;
  evt_code_t pick_idx;
  logic      accept;
  logic      load;
  evt_vec_t  load_mask;

  evt_rr_pick u_pick (
    .pending (pending),
    .ptr     (ptr),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  // Only registered pending is eligible; events arriving this edge wait one cycle.
  always_comb begin
    accept    = (slot_state == SLOT_FULL) && stream.code_ready;
    load      = ((slot_state == SLOT_EMPTY) || accept) && pick_found;
    load_mask = load ? (evt_vec_t'(1) << pick_idx) : '0;
  end

  assign stream.code_valid = (slot_state == SLOT_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_state      <= SLOT_EMPTY;
      stream.code_out <= '0;
      ptr             <= '0;
      pending         <= '0;
      overflow        <= 1'b0;
    end else begin
      // Set wins over the load-clear on the same bit.
      pending  <= (pending & ~load_mask) | evt_in;
      overflow <= |(evt_in & pending & ~load_mask);
      case (slot_state)
        SLOT_EMPTY: begin
          if (load) begin
            slot_state      <= SLOT_FULL;
            stream.code_out <= pick_idx;
            ptr             <= pick_idx + 3'd1;
          end
        end
        SLOT_FULL: begin
          if (load) begin
            stream.code_out <= pick_idx;
            ptr             <= pick_idx + 3'd1;
          end else if (accept) begin
            slot_state <= SLOT_EMPTY;
          end
        end
        default: slot_state <= SLOT_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_evt_code_serializer.sv
// Directed bench for evt_code_serializer: reset, single event, burst,
// round-robin wrap, backpressure/overflow, set-wins collision, async reset.
module tb_evt_code_serializer;
  import evt_code_pkg::*;

  logic        clk;
  logic        rst_n;
  evt_vec_t    evt_in;
  evt_vec_t    pending;
  logic        overflow;
  slot_state_t slot_state;
  int          checks;
  int          failures;

  evt_code_serializer_if bus ();

  evt_code_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .evt_in     (evt_in),
    .stream     (bus.master),
    .pending    (pending),
    .overflow   (overflow),
    .slot_state (slot_state)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0;
    evt_in = '0;
    bus.code_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    evt_in = '0;
    bus.code_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.code_valid !== 1'b0 || bus.code_out !== 3'd0) begin
      failures++;
      $display("FAIL reset_stream got valid=%0b code=%0d exp valid=0 code=0", bus.code_valid, bus.code_out);
    end
    checks++;
    if (pending !== 8'h00 || overflow !== 1'b0 || slot_state !== SLOT_EMPTY) begin
      failures++;
      $display("FAIL reset_state got pending=%h ovf=%0b state=%0d exp 00/0/0", pending, overflow, slot_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bus.code_ready = 1'b1;
    evt_in = 8'b0010_0000;
    @(negedge clk);
    evt_in = '0;
    checks++;
    if (pending !== 8'h20 || bus.code_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_pend got pending=%h valid=%0b exp 20/0", pending, bus.code_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.code_valid !== 1'b1 || bus.code_out !== 3'd5 || pending !== 8'h00) begin
      failures++;
      $display("FAIL single_code got valid=%0b code=%0d pending=%h exp 1/5/00", bus.code_valid, bus.code_out, pending);
    end
    @(negedge clk);
    checks++;
    if (bus.code_valid !== 1'b0 || bus.code_out !== 3'd5) begin
      failures++;
      $display("FAIL single_drain got valid=%0b code=%0d exp 0/5", bus.code_valid, bus.code_out);
    end
  endtask

  task automatic test_burst();
    logic [CODE_W-1:0] exp_q[$];
    logic [CODE_W-1:0] exp_code;
    apply_reset();
    for (int i = 0; i < N_EVT; i++) exp_q.push_back(CODE_W'(i));
    bus.code_ready = 1'b1;
    evt_in = 8'hFF;
    @(negedge clk);
    evt_in = '0;
    checks++;
    if (pending !== 8'hFF) begin
      failures++;
      $display("FAIL burst_pend got pending=%h exp ff", pending);
    end
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_code = exp_q.pop_front();
      checks++;
      if (bus.code_valid !== 1'b1 || bus.code_out !== exp_code || overflow !== 1'b0) begin
        failures++;
        $display("FAIL burst_code got valid=%0b code=%0d ovf=%0b exp 1/%0d/0", bus.code_valid, bus.code_out, overflow, exp_code);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.code_valid !== 1'b0 || pending !== 8'h00) begin
      failures++;
      $display("FAIL burst_end got valid=%0b pending=%h exp 0/00", bus.code_valid, pending);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    evt_in = 8'h20;
    @(negedge clk);
    evt_in = 8'h21;
    bus.code_ready = 1'b1;
    @(negedge clk);
    evt_in = '0;
    checks++;
    if (bus.code_out !== 3'd5 || pending !== 8'h21) begin
      failures++;
      $display("FAIL rr_first got code=%0d pending=%h exp 5/21", bus.code_out, pending);
    end
    @(negedge clk);
    checks++;
    if (bus.code_valid !== 1'b1 || bus.code_out !== 3'd0) begin
      failures++;
      $display("FAIL rr_wrap got valid=%0b code=%0d exp 1/0", bus.code_valid, bus.code_out);
    end
    @(negedge clk);
    checks++;
    if (bus.code_valid !== 1'b1 || bus.code_out !== 3'd5 || pending !== 8'h00) begin
      failures++;
      $display("FAIL rr_second got valid=%0b code=%0d pending=%h exp 1/5/00", bus.code_valid, bus.code_out, pending);
    end
    @(negedge clk);
    checks++;
    if (bus.code_valid !== 1'b0) begin
      failures++;
      $display("FAIL rr_drain got valid=%0b exp 0", bus.code_valid);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    evt_in = 8'h08;
    @(negedge clk);
    evt_in = '0;
    @(negedge clk);
    checks++;
    if (bus.code_valid !== 1'b1 || bus.code_out !== 3'd3 || pending !== 8'h00) begin
      failures++;
      $display("FAIL bp_hold got valid=%0b code=%0d pending=%h exp 1/3/00", bus.code_valid, bus.code_out, pending);
    end
    evt_in = 8'h08;
    @(negedge clk);
    checks++;
    if (pending !== 8'h08 || overflow !== 1'b0 || bus.code_out !== 3'd3) begin
      failures++;
      $display("FAIL bp_first got pending=%h ovf=%0b code=%0d exp 08/0/3", pending, overflow, bus.code_out);
    end
    @(negedge clk);
    evt_in = '0;
    checks++;
    if (overflow !== 1'b1 || pending !== 8'h08) begin
      failures++;
      $display("FAIL bp_ovf got ovf=%0b pending=%h exp 1/08", overflow, pending);
    end
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || bus.code_valid !== 1'b1 || bus.code_out !== 3'd3) begin
      failures++;
      $display("FAIL bp_pulse got ovf=%0b valid=%0b code=%0d exp 0/1/3", overflow, bus.code_valid, bus.code_out);
    end
    bus.code_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.code_valid !== 1'b1 || bus.code_out !== 3'd3 || pending !== 8'h00) begin
      failures++;
      $display("FAIL bp_reload got valid=%0b code=%0d pending=%h exp 1/3/00", bus.code_valid, bus.code_out, pending);
    end
    @(negedge clk);
    checks++;
    if (bus.code_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got valid=%0b exp 0", bus.code_valid);
    end
  endtask

  task automatic test_set_wins();
    apply_reset();
    evt_in = 8'h04;
    @(negedge clk);
    bus.code_ready = 1'b1;
    @(negedge clk);
    evt_in = '0;
    checks++;
    if (bus.code_out !== 3'd2 || pending !== 8'h04 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL setwins_first got code=%0d pending=%h ovf=%0b exp 2/04/0", bus.code_out, pending, overflow);
    end
    @(negedge clk);
    checks++;
    if (bus.code_valid !== 1'b1 || bus.code_out !== 3'd2 || pending !== 8'h00) begin
      failures++;
      $display("FAIL setwins_again got valid=%0b code=%0d pending=%h exp 1/2/00", bus.code_valid, bus.code_out, pending);
    end
    @(negedge clk);
    checks++;
    if (bus.code_valid !== 1'b0) begin
      failures++;
      $display("FAIL setwins_drain got valid=%0b exp 0", bus.code_valid);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    evt_in = 8'h01;
    @(negedge clk);
    evt_in = 8'h0C;
    @(negedge clk);
    evt_in = '0;
    checks++;
    if (bus.code_valid !== 1'b1 || pending !== 8'h0C) begin
      failures++;
      $display("FAIL arst_setup got valid=%0b pending=%h exp 1/0c", bus.code_valid, pending);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.code_valid !== 1'b0 || bus.code_out !== 3'd0 || pending !== 8'h00 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL arst_clear got valid=%0b code=%0d pending=%h ovf=%0b exp 0/0/00/0", bus.code_valid, bus.code_out, pending, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.code_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.code_valid !== 1'b0 || pending !== 8'h00 || overflow !== 1'b0) begin
        failures++;
        $display("FAIL arst_stale got valid=%0b pending=%h ovf=%0b exp 0/00/0", bus.code_valid, pending, overflow);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    evt_in = '0;
    bus.code_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_round_robin();
    test_backpressure();
    test_set_wins();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
